instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface: owns the PC, drives InstrAddr,

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port, redirect input and the decode-side valid/ready queue head.
// master = the fetch unit; slave = memory, branch logic and decode.
interface instruction_fetch_unit_if;
    logic [63:0] startPC;
    logic [63:0] InstrAddr;
    logic [31:0] InstrData;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstr;
    logic [63:0] OutPC;
    logic        Halted;

    modport master (
        input  startPC, InstrData, Redirect, RedirectPC, OutReady,
        output InstrAddr, OutValid, OutInstr, OutPC, Halted
    );

    modport slave (
        output startPC, InstrData, Redirect, RedirectPC, OutReady,
        input  InstrAddr, OutValid, OutInstr, OutPC, Halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: holds the PC on InstrAddr for WAIT_CYCLES edges, captures InstrData,
// and queues {PC,instr} for decode; redirects flush the queue, fetch stops at PC_LIMIT.
module instruction_fetch_unit #(
    parameter int          WAIT_CYCLES = 3,
    parameter int          DEPTH       = 2,
    parameter logic [63:0] PC_LIMIT    = 64'h58
) (
    input logic                      CLK,
    input logic                      resetl,
    instruction_fetch_unit_if.master fetch
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [PW:0]   FIFO_FULL  = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAPTURE_STALL,
        ST_HALT
    } fetchState_t;

    fetchState_t state;
    logic [63:0] pc;
    logic [CW-1:0] cnt;

    logic [31:0] instrBuf [DEPTH];
    logic [63:0] pcBuf    [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;

    logic        pop;
    logic        pushAllowed;
    logic        captureNow;
    logic        push;
    logic [63:0] nextPc;
    logic [63:0] redirectTarget;

    // A pop on the same edge frees the slot, so a full queue can still accept a push.
    always_comb begin
        pop            = (count != '0) && fetch.OutReady;
        pushAllowed    = (count != FIFO_FULL) || pop;
        captureNow     = ((state == ST_WAIT) && (cnt == '0)) || (state == ST_CAPTURE_STALL);
        push           = captureNow && pushAllowed;
        nextPc         = pc + 64'd4;
        redirectTarget = fetch.RedirectPC & ~64'h3;
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            pc    <= fetch.startPC & ~64'h3;
            cnt   <= CNT_RELOAD;
            state <= ST_WAIT;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instrBuf[i] <= '0;
                pcBuf[i]    <= '0;
            end
        end else if (fetch.Redirect) begin
            pc    <= redirectTarget;
            cnt   <= CNT_RELOAD;
            state <= (redirectTarget >= PC_LIMIT) ? ST_HALT : ST_WAIT;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                instrBuf[wrPtr] <= fetch.InstrData;
                pcBuf[wrPtr]    <= pc;
                wrPtr           <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            case (state)
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (push) begin
                        pc    <= nextPc;
                        cnt   <= CNT_RELOAD;
                        state <= (nextPc >= PC_LIMIT) ? ST_HALT : ST_WAIT;
                    end else begin
                        state <= ST_CAPTURE_STALL;
                    end
                end
                ST_CAPTURE_STALL: begin
                    if (push) begin
                        pc    <= nextPc;
                        cnt   <= CNT_RELOAD;
                        state <= (nextPc >= PC_LIMIT) ? ST_HALT : ST_WAIT;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

    assign fetch.InstrAddr = pc;
    assign fetch.OutValid  = (count != '0);
    assign fetch.OutInstr  = instrBuf[rdPtr];
    assign fetch.OutPC     = pcBuf[rdPtr];
    assign fetch.Halted    = (state == ST_HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected {PC,instr,cycle} entries are queued by the
// stimulus and a negedge monitor pops and compares each one as decode accepts it.
module tb_instruction_fetch_unit;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        int          cycle;
    } expect_t;

    logic CLK = 1'b0;
    logic resetl;
    instruction_fetch_unit_if ifc();

    instruction_fetch_unit #(
        .WAIT_CYCLES(3),
        .DEPTH      (2),
        .PC_LIMIT   (64'h58)
    ) dut (
        .CLK   (CLK),
        .resetl(resetl),
        .fetch (ifc.master)
    );

    always #5 CLK = ~CLK;

    logic [31:0] image [0:31];
    assign ifc.InstrData = (ifc.InstrAddr < 64'h80) ? image[ifc.InstrAddr[6:2]] : 32'h0;

    expect_t sbQueue[$];
    expect_t head;
    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int b;
    int t;

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    task automatic applyStimulus(input logic rstl, input logic ready, input logic redirect,
                                 input logic [63:0] rpc);
        resetl         = rstl;
        ifc.OutReady   = ready;
        ifc.Redirect   = redirect;
        ifc.RedirectPC = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    task automatic expectEntry(input logic [63:0] pc, input logic [31:0] instr, input int cycle);
        expect_t e;
        e.pc    = pc;
        e.instr = instr;
        e.cycle = cycle;
        sbQueue.push_back(e);
    endtask

    task automatic gotoCycle(input int c);
        while (cycleCount < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One reset edge, then the documented reset values; leaves resetl released, OutReady low.
    task automatic applyReset(input logic [63:0] spc, output int base);
        checkOutput("scoreboard_drained_before_reset", 64'(sbQueue.size()), 64'd0);
        ifc.startPC = spc;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        @(posedge CLK);
        #1;
        base = cycleCount;
        checkOutput("reset_OutValid", 64'(ifc.OutValid), 64'd0);
        checkOutput("reset_OutInstr", 64'(ifc.OutInstr), 64'd0);
        checkOutput("reset_OutPC", ifc.OutPC, 64'd0);
        checkOutput("reset_Halted", 64'(ifc.Halted), 64'd0);
        checkOutput("reset_InstrAddr", ifc.InstrAddr, spc & ~64'h3);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    endtask

    // Scoreboard monitor: every accepted head entry must match the next expected entry and cycle.
    always @(negedge CLK) begin
        if (resetl === 1'b1 && ifc.OutValid === 1'b1 && ifc.OutReady === 1'b1) begin
            checks++;
            if (sbQueue.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_entry: got pc %h instr %h at cycle %0d, expected none",
                         ifc.OutPC, ifc.OutInstr, cycleCount);
            end else begin
                head = sbQueue.pop_front();
                if (ifc.OutPC !== head.pc || ifc.OutInstr !== head.instr || cycleCount != head.cycle) begin
                    errors++;
                    $display("[TB] FAIL entry: got pc %h instr %h cycle %0d, expected pc %h instr %h cycle %0d",
                             ifc.OutPC, ifc.OutInstr, cycleCount, head.pc, head.instr, head.cycle);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            image[i] = (i < 22) ? (32'hD000_0000 | 32'(i * 4)) : 32'h0;
        end
        image[0]  = 32'hF84003E9;
        image[1]  = 32'hF84083EA;
        image[2]  = 32'hF84103EB;
        image[8]  = 32'h8B0901AD;
        image[13] = 32'hD29BDE09;
        image[19] = 32'h8B0C0149;
        image[20] = 32'hF80283E9;
        image[21] = 32'hF84283EA;

        ifc.startPC = 64'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);

        $display("[TB] streaming fetch from PC 0");
        applyReset(64'h0, b);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        expectEntry(64'h0, 32'hF84003E9, b + 3);
        expectEntry(64'h4, 32'hF84083EA, b + 6);
        expectEntry(64'h8, 32'hF84103EB, b + 9);
        gotoCycle(b + 10);

        $display("[TB] backpressure fills the queue");
        applyReset(64'h0, b);
        gotoCycle(b + 12);
        checkOutput("stall_InstrAddr", ifc.InstrAddr, 64'h8);
        checkOutput("stall_OutValid", 64'(ifc.OutValid), 64'd1);
        checkOutput("stall_OutPC", ifc.OutPC, 64'h0);
        checkOutput("stall_OutInstr", 64'(ifc.OutInstr), 64'hF84003E9);
        t = b + 12;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        expectEntry(64'h0, 32'hF84003E9, t);
        expectEntry(64'h4, 32'hF84083EA, t + 1);
        expectEntry(64'h8, 32'hF84103EB, t + 2);
        gotoCycle(t + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);

        $display("[TB] redirect with a full queue");
        gotoCycle(t + 11);
        checkOutput("prered_OutValid", 64'(ifc.OutValid), 64'd1);
        checkOutput("prered_OutPC", ifc.OutPC, 64'hC);
        checkOutput("prered_OutInstr", 64'(ifc.OutInstr), 64'hD000000C);
        checkOutput("prered_InstrAddr", ifc.InstrAddr, 64'h14);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h22);
        gotoCycle(t + 12);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("redirect_OutValid", 64'(ifc.OutValid), 64'd0);
        checkOutput("redirect_InstrAddr", ifc.InstrAddr, 64'h20);
        expectEntry(64'h20, 32'h8B0901AD, t + 15);
        gotoCycle(t + 16);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);

        $display("[TB] reset mid-wait with entries queued");
        gotoCycle(t + 22);
        checkOutput("prereset_OutValid", 64'(ifc.OutValid), 64'd1);
        checkOutput("prereset_OutPC", ifc.OutPC, 64'h24);
        applyReset(64'h4E, b);

        $display("[TB] fetch up to the end address");
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        expectEntry(64'h4C, 32'h8B0C0149, b + 3);
        expectEntry(64'h50, 32'hF80283E9, b + 6);
        expectEntry(64'h54, 32'hF84283EA, b + 9);
        gotoCycle(b + 8);
        checkOutput("prehalt_Halted", 64'(ifc.Halted), 64'd0);
        gotoCycle(b + 9);
        checkOutput("halt_Halted", 64'(ifc.Halted), 64'd1);
        gotoCycle(b + 15);
        checkOutput("halt_hold_Halted", 64'(ifc.Halted), 64'd1);
        checkOutput("halt_hold_OutValid", 64'(ifc.OutValid), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h34);
        gotoCycle(b + 16);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("unhalt_Halted", 64'(ifc.Halted), 64'd0);
        checkOutput("unhalt_InstrAddr", ifc.InstrAddr, 64'h34);
        expectEntry(64'h34, 32'hD29BDE09, b + 19);

        $display("[TB] redirect colliding with push and pop");
        gotoCycle(b + 20);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        expectEntry(64'h38, 32'hD0000038, b + 24);
        gotoCycle(b + 24);
        checkOutput("collide_pre_OutValid", 64'(ifc.OutValid), 64'd1);
        checkOutput("collide_pre_OutPC", ifc.OutPC, 64'h38);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h10);
        gotoCycle(b + 25);
        checkOutput("collide_OutValid", 64'(ifc.OutValid), 64'd0);
        checkOutput("collide_InstrAddr", ifc.InstrAddr, 64'h10);
        checkOutput("collide_Halted", 64'(ifc.Halted), 64'd0);
        checkOutput("collide_scoreboard_drained", 64'(sbQueue.size()), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h60);
        gotoCycle(b + 26);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("far_redirect_Halted", 64'(ifc.Halted), 64'd1);
        checkOutput("far_redirect_InstrAddr", ifc.InstrAddr, 64'h60);
        checkOutput("far_redirect_OutValid", 64'(ifc.OutValid), 64'd0);
        gotoCycle(b + 32);
        checkOutput("final_Halted", 64'(ifc.Halted), 64'd1);
        checkOutput("final_OutValid", 64'(ifc.OutValid), 64'd0);
        checkOutput("final_scoreboard_drained", 64'(sbQueue.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
